fetch_pc: RTL
=============

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 RESET_PC: parameter, default 32'h0000_3000, the first fetch address after reset SHALL be RESET_PC.
REQ-002 clk  input  1  single clock; every register SHALL update on the rising edge only.
REQ-003 rst_n  input  1  reset SHALL be synchronous and active-low.
REQ-004 PCsrc  input  1  redirect request from branch resolution; SHALL be qualified only by itself.
REQ-005 target  input  32  redirect address; SHALL be sampled only when PCsrc=1.
REQ-006 stall  input  1  SHALL block the issue of a new fetch request.
REQ-007 imem_req_valid  output  1 / imem_req_ready  input  1 / imem_addr  output  32: request handshake.
REQ-008 imem_rsp_valid  input  1 / imem_rdata  input  32: one response per accepted request, latency of 1 or more cycles.
REQ-009 inst_valid  output  1 / inst_ready  input  1 / inst  output  32 / inst_pc  output  32: decode handshake.
REQ-010 misalign  output  1  one-cycle pulse on a rejected redirect; SHALL be tied to 0 when ALIGN_CHECK_EN is undefined.

Function
REQ-011 FSM SHALL have three states: REQ, WAIT and FULL; at most one request SHALL be outstanding.
REQ-012 REQ state SHALL drive imem_req_valid=!stall and imem_addr=pc.
- On valid&ready: pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), req_pc<=pc, go to WAIT.
REQ-013 WAIT state, on imem_rsp_valid:
- kill=0: inst<=imem_rdata, inst_pc<=req_pc, inst_valid<=1, go to FULL.
- kill=1: drop the response, clear kill, go to REQ.
REQ-014 FULL state SHALL hold inst, inst_pc and inst_valid stable until inst_valid&inst_ready, then clear inst_valid and go to REQ.
REQ-015 A redirect (PCsrc=1) SHALL load pc<=target next cycle and SHALL take priority over stall and pc+4.
REQ-016 Redirect in REQ without a handshake: go to REQ with the new pc.
- With a handshake in the same cycle: the old-address request is outstanding, so kill<=1 and go to WAIT.
REQ-017 Redirect in WAIT SHALL set kill<=1.
- If imem_rsp_valid is high in the same cycle, the response SHALL be dropped and the FSM goes to REQ with kill=0.
REQ-018 Redirect in FULL SHALL clear inst_valid (no handshake is counted) and go to REQ.
REQ-019 Throughput: a response received in cycle N SHALL give inst_valid=1 in cycle N+1.
- The earliest next request SHALL be the cycle after the inst handshake.
REQ-020 Stall SHALL NOT affect WAIT or FULL behaviour.

Reset
REQ-021 When rst_n=0 at an edge: pc=RESET_PC, state=REQ, kill=0, inst_valid=0, inst=0, inst_pc=0, misalign=0.
REQ-022 A reset during WAIT SHALL discard any later stale response; the first imem_req_valid SHALL appear in the first cycle after rst_n=1.

Configuration
REQ-023 Macro FETCH_PC_ALIGN_CHECK_EN.
- Defined: a redirect with target[1:0]!=0 SHALL be ignored (pc, state and kill unchanged) and misalign SHALL pulse for 1 cycle.
- Undefined: target[1:0] SHALL be forced to 2'b00 and misalign SHALL stay 0.

Structure
REQ-024 Package fetch_pkg SHALL hold the FSM state enum, the default RESET_PC, and INST_W=32.
REQ-025 Sub-module pc_next (combinational next-pc mux: redirect / pc+4 / hold, plus the alignment check) SHALL be instantiated once.

Verification
REQ-026 Reset release, ready=1, rsp latency 1, inst_ready=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008, with inst_pc matching.
REQ-027 PCsrc=1, target=0x4000 while in WAIT, rsp arrives 2 cycles later -> that response is dropped, inst_valid stays 0, next imem_addr=0x4000.
REQ-028 inst_ready=0 for 5 cycles in FULL -> inst and inst_pc stable, imem_req_valid=0 throughout.
REQ-029 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-030 With the macro defined, PCsrc=1, target=0x4002 -> misalign=1 for 1 cycle, next address still pc+4.
- Without the macro, the same stimulus -> next address 0x4000.
REQ-031 stall=1 in REQ for 3 cycles, then PCsrc=1 target=0x5000 -> no request while stalled, then imem_addr=0x5000 after stall drops.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pc shared types: FSM states, default reset vector, word width.
// Optional alignment check: FETCH_PC_ALIGN_CHECK_EN.
package fetch_pkg;

  localparam int INST_W = 32;

  localparam logic [31:0] RESET_PC_DEF =
    32'h0000_3000;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_FULL
  } state_e;

endpackage

// File: rtl/fetch_pc_if.sv
// Instruction-memory and decode handshakes of fetch_pc.
// master = fetch side, slave = memory/decode side.
interface fetch_pc_if;
  import fetch_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [31:0]       imem_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [31:0]       inst_pc;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/pc_next.sv
// Next-pc mux: redirect, sequential +4 or hold.
// Alignment rejection only with FETCH_PC_ALIGN_CHECK_EN.
module pc_next
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pcsrc,
  input  logic [31:0] target,
  input  logic        adv,
  output logic [31:0] pc_d,
`ifdef FETCH_PC_ALIGN_CHECK_EN
  output logic        bad,
`endif
  output logic        redir
);

  logic [31:0] tgt;

`ifdef FETCH_PC_ALIGN_CHECK_EN
  assign bad   = pcsrc && (target[1:0] != 2'b00);
  assign redir = pcsrc && !bad;
  assign tgt   = target;
`else
  assign redir = pcsrc;
  assign tgt   = target & ~32'h3;
`endif

  always_comb begin
    pc_d = pc;
    if (redir)
      pc_d = tgt;
    else if (adv)
      pc_d = pc + 32'd4;
  end

endmodule

// File: rtl/fetch_pc.sv
// Fetch PC unit: one outstanding imem request, one held instruction.
// Alignment check enabled by FETCH_PC_ALIGN_CHECK_EN.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCsrc,
  input  logic [31:0] target,
  input  logic        stall,
  output logic        misalign,
  fetch_pc_if.master  bus
);

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       req_pc_q, req_pc_d;
  logic              kill_q, kill_d;
  logic              inst_valid_q, inst_valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [31:0]       inst_pc_q, inst_pc_d;
  logic              req_valid;
  logic              hs;
  logic              redir;

  assign req_valid = (state_q == S_REQ) && !stall;
  assign hs        = req_valid && bus.imem_req_ready;

`ifdef FETCH_PC_ALIGN_CHECK_EN
  logic bad;
  logic misalign_q;

  pc_next u_pc_next (
    .pc     (pc_q),
    .pcsrc  (PCsrc),
    .target (target),
    .adv    (hs),
    .pc_d   (pc_d),
    .bad    (bad),
    .redir  (redir)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_q <= 1'b0;
    else
      misalign_q <= bad;
  end

  assign misalign = misalign_q;
`else
  pc_next u_pc_next (
    .pc     (pc_q),
    .pcsrc  (PCsrc),
    .target (target),
    .adv    (hs),
    .pc_d   (pc_d),
    .redir  (redir)
  );

  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    unique case (state_q)
      S_REQ: begin
        if (hs) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          // old-address request is in flight
          kill_d   = redir;
        end
      end
      S_WAIT: begin
        if (redir) begin
          if (bus.imem_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d       = bus.imem_rdata;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (redir || bus.inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'd0;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule
